// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared definitions for the switch egress path: header word field positions,
// FIFO entry valid-marker position, port count and the scheduler FSM encoding.
// -----------------------------------------------------------------------------
package switch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PTR_W     = 2;

  // FIFO entry is {valid, word}; the marker sits just above the data word.
  localparam int VALID_BIT = 32;

  // Header word layout
  localparam int DEST_MSB = 31;
  localparam int DEST_LSB = 24;
  localparam int LEN_MSB  = 23;
  localparam int LEN_LSB  = 8;
  localparam int SEQ_MSB  = 7;
  localparam int SEQ_LSB  = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } sched_state_t;

  // Payload words still to come after the header; a zero length is a
  // header-only packet, the same as a length of one.
  function automatic logic [15:0] words_after_header(input logic [15:0] len);
    return (len == 16'd0) ? 16'd0 : (len - 16'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Pointer-based round-robin pick among NUM_PORTS requesters. Purely
// combinational: the first requester at or after i_ptr (wrapping) wins.
// Ports:
//   i_req   [NUM_PORTS-1:0]  request vector (input FIFO non-empty)
//   i_ptr   [PTR_W-1:0]      highest-priority index this round
//   o_pick  [PTR_W-1:0]      winning index (0 when nothing requests)
//   o_found                  at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import switch_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [PTR_W-1:0]     o_pick,
  output logic                 o_found
);

  logic [PTR_W-1:0] w_idx;

  // Walk from the farthest offset back to the pointer so the nearest
  // requester is the last (and therefore winning) assignment.
  always_comb begin
    o_found = 1'b0;
    o_pick  = '0;
    w_idx   = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      w_idx = i_ptr + PTR_W'(off);
      if (i_req[w_idx]) begin
        o_found = 1'b1;
        o_pick  = w_idx;
      end
    end
  end

endmodule

// File: rtl/output_port_scheduler.sv
// -----------------------------------------------------------------------------
// output_port_scheduler
// Egress stage of one switch output port. Drains the per-input packet FIFOs
// (first-word-fall-through) one whole packet at a time onto a 32-bit
// valid/ready stream, with round-robin choice of the next input.
//
// State table:
//   ST_IDLE | no packet in flight; pick next non-empty input from rr pointer
//   ST_XFER | forwarding the granted input's packet until its last word pops
//
// Ports:
//   clk, rst       clock / synchronous active-high reset
//   fifo_empty     per-input FIFO empty flags
//   fifo_dout      per-input head entries {valid, word}, input 0 in low bits
//   fifo_rd_en     one-hot pop strobe to the granted FIFO
//   out_word       egress data word
//   out_valid      out_word valid; accepted when out_ready is also high
//   out_ready      egress backpressure
//   out_sop        out_word is a header
//   out_eop        out_word is the last word of the packet
//   grant          input currently granted
//   err_dest       pulse: popped header has dest_id != PORT_ID
//   err_invalid    pulse: dropped an entry whose valid marker was clear
//   pkt_count      packets completed since reset (wraps)
// -----------------------------------------------------------------------------
module output_port_scheduler
  import switch_pkg::*;
#(
  parameter int PORT_ID = 1,
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             fifo_empty,
  input  logic [NUM_IN*(DATA_W+1)-1:0]  fifo_dout,
  output logic [NUM_IN-1:0]             fifo_rd_en,
  output logic [DATA_W-1:0]             out_word,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [PTR_W-1:0]              grant,
  output logic                          err_dest,
  output logic                          err_invalid,
  output logic [15:0]                   pkt_count
);

  sched_state_t     r_state;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_grant;
  logic [15:0]      r_remain;
  logic             r_sop;
  logic [15:0]      r_pkt_count;

  logic [PTR_W-1:0] w_pick;
  logic             w_found;
  logic [DATA_W:0]  w_entry;
  logic             w_head_avail;
  logic             w_xfer;
  logic             w_valid;
  logic             w_drop;
  logic             w_accept;
  logic [15:0]      w_len;
  logic             w_eop;

  rr_arbiter u_rr_arbiter (
    .i_req   (~fifo_empty),
    .i_ptr   (r_rr_ptr),
    .o_pick  (w_pick),
    .o_found (w_found)
  );

  assign w_entry      = fifo_dout[r_grant*(DATA_W+1) +: (DATA_W+1)];
  assign w_head_avail = !fifo_empty[r_grant];
  // Outputs are combinational off the FIFO head; holding them low while rst
  // is high keeps a mid-packet reset from popping or presenting a word.
  assign w_xfer       = (r_state == ST_XFER) && !rst;
  assign w_valid      = w_xfer && w_head_avail && w_entry[VALID_BIT];
  assign w_drop       = w_xfer && w_head_avail && !w_entry[VALID_BIT];
  assign w_accept     = w_valid && out_ready;
  assign w_len        = w_entry[LEN_MSB:LEN_LSB];
  assign w_eop        = w_valid && ((r_sop && (w_len <= 16'd1)) ||
                                    (!r_sop && (r_remain == 16'd1)));

  assign fifo_rd_en  = (w_accept || w_drop) ? (NUM_IN'(1) << r_grant) : '0;
  assign out_word    = w_xfer ? w_entry[DATA_W-1:0] : '0;
  assign out_valid   = w_valid;
  assign out_sop     = w_valid && r_sop;
  assign out_eop     = w_eop;
  assign err_dest    = w_accept && r_sop &&
                       (w_entry[DEST_MSB:DEST_LSB] != 8'(PORT_ID));
  assign err_invalid = w_drop;
  assign grant       = r_grant;
  assign pkt_count   = r_pkt_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_remain    <= '0;
      r_sop       <= 1'b1;
      r_pkt_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_sop   <= 1'b1;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Dropped invalid entries never reach here: only accepted words
          // advance the packet.
          if (w_accept) begin
            if (w_eop) begin
              r_state     <= ST_IDLE;
              r_rr_ptr    <= r_grant + PTR_W'(1);
              r_pkt_count <= r_pkt_count + 16'd1;
              r_sop       <= 1'b1;
              r_remain    <= '0;
            end else if (r_sop) begin
              r_remain <= words_after_header(w_len);
              r_sop    <= 1'b0;
            end else begin
              r_remain <= r_remain - 16'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
